// File: rtl/branch_unit.sv
// branch_unit: resolves branches against a flag register, squashes one shadow slot after a taken
// branch, and keeps a circular return-address stack for bl/ret.
module branch_unit #(
  parameter int ADDR_W    = 32,
  parameter int RAS_DEPTH = 4,
  parameter int PC_STEP   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flag_we,
  input  logic              alu_zero,
  input  logic              alu_carry,
  input  logic              alu_sign,
  input  logic              br_valid,
  input  logic [3:0]        br_type,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic [ADDR_W-1:0] imm_target,
  input  logic [ADDR_W-1:0] reg_target,
  output logic              taken,
  output logic [ADDR_W-1:0] next_pc,
  output logic              flush,
  output logic              ras_overflow,
  output logic              ras_underflow
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(RAS_DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(RAS_DEPTH);
  typedef enum logic {NORMAL, SHADOW} state_t;
  state_t state;
  logic z, c, s;
  logic [ADDR_W-1:0] stack [RAS_DEPTH];
  logic [PW-1:0] ptr, prev, nxt;
  logic [CW-1:0] cnt;
  logic hit, push, pop, res, empty;
  logic [ADDR_W-1:0] tgt;
  // ptr is the next write slot; when full it also points at the oldest entry
  assign prev  = ptr == '0 ? LAST : ptr - 1'b1;
  assign nxt   = ptr == LAST ? '0 : ptr + 1'b1;
  assign empty = cnt == '0;
  always_comb begin
    hit  = 1'b1;
    tgt  = imm_target;
    push = 1'b0;
    pop  = 1'b0;
    case (br_type)
      4'h0: tgt = reg_target;
      4'h1: hit = 1'b1;
      4'h2: hit = z;
      4'h3: hit = !z;
      4'h4: push = 1'b1;
      4'h5: hit = c;
      4'h6: hit = s;
      4'h7: hit = !c;
      4'h8: begin
        pop = 1'b1;
        tgt = empty ? reg_target : stack[prev];
      end
      default: hit = 1'b0;
    endcase
  end
  assign res = br_valid && state == NORMAL && hit;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= NORMAL;
      {z, c, s}     <= 3'b000;
      ptr           <= '0;
      cnt           <= '0;
      taken         <= 1'b0;
      flush         <= 1'b0;
      next_pc       <= '0;
      ras_overflow  <= 1'b0;
      ras_underflow <= 1'b0;
    end else begin
      if (flag_we) {z, c, s} <= {alu_zero, alu_carry, alu_sign};
      taken         <= res;
      flush         <= res;
      ras_underflow <= res && pop && empty;
      ras_overflow  <= ras_overflow || (res && push && cnt == FULL);
      state         <= res ? SHADOW : NORMAL;
      if (res) next_pc <= tgt;
      if (res && push) begin
        ptr <= nxt;
        cnt <= cnt == FULL ? cnt : cnt + 1'b1;
      end
      if (res && pop && !empty) begin
        ptr <= prev;
        cnt <= cnt - 1'b1;
      end
    end
  end
  always_ff @(posedge clk)
    if (res && push) stack[ptr] <= pc_in + ADDR_W'(PC_STEP);
endmodule

// File: tb/tb_branch_unit.sv
// tb_branch_unit: directed and randomized checks of branch_unit against a queue-based model.
module tb_branch_unit;
  localparam int D = 4;
  logic clk = 1'b0, rst_n = 1'b0;
  logic flag_we = 0, alu_zero = 0, alu_carry = 0, alu_sign = 0, br_valid = 0;
  logic [3:0] br_type = '0;
  logic [31:0] pc_in = '0, imm_target = '0, reg_target = '0;
  logic taken, flush, ras_overflow, ras_underflow;
  logic [31:0] next_pc;
  int n_chk = 0, n_pass = 0;
  logic [2:0] m_flags;
  logic m_sh, m_ovf;
  logic [31:0] m_pc, ras [$];

  branch_unit #(.ADDR_W(32), .RAS_DEPTH(D), .PC_STEP(4)) dut (
    .clk(clk), .rst_n(rst_n), .flag_we(flag_we), .alu_zero(alu_zero), .alu_carry(alu_carry),
    .alu_sign(alu_sign), .br_valid(br_valid), .br_type(br_type), .pc_in(pc_in),
    .imm_target(imm_target), .reg_target(reg_target), .taken(taken), .next_pc(next_pc),
    .flush(flush), .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_taken", taken, 0);
    check("rst_flush", flush, 0);
    check("rst_pc", next_pc, 0);
    check("rst_ovf", ras_overflow, 0);
    check("rst_unf", ras_underflow, 0);
    m_flags = 3'b000; m_sh = 0; m_ovf = 0; m_pc = '0; ras.delete();
    #1 rst_n = 1'b1;
  endtask

  task automatic cyc(input logic fwe, input logic [2:0] f, input logic bv, input logic [3:0] bt,
                     input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] rg);
    logic tk, unf;
    logic [31:0] tg;
    flag_we = fwe; {alu_zero, alu_carry, alu_sign} = f;
    br_valid = bv; br_type = bt; pc_in = pc; imm_target = imm; reg_target = rg;
    tk = 0; unf = 0; tg = imm;
    if (!m_sh && bv) begin
      case (bt)
        0: begin tk = 1; tg = rg; end
        1: tk = 1;
        2: tk = m_flags[2];
        3: tk = !m_flags[2];
        4: begin
          tk = 1;
          if (ras.size() == D) begin void'(ras.pop_front()); m_ovf = 1; end
          ras.push_back(pc + 32'd4);
        end
        5: tk = m_flags[1];
        6: tk = m_flags[0];
        7: tk = !m_flags[1];
        8: begin
          tk = 1;
          if (ras.size() > 0) tg = ras.pop_back();
          else begin tg = rg; unf = 1; end
        end
        default: tk = 0;
      endcase
    end
    if (tk) m_pc = tg;
    m_sh = tk;
    if (fwe) m_flags = f;
    @(posedge clk);
    #1;
    check("taken", taken, tk);
    check("flush", flush, tk);
    check("next_pc", next_pc, m_pc);
    check("ovf", ras_overflow, m_ovf);
    check("unf", ras_underflow, unf);
  endtask

  task automatic idle();
    cyc(0, 3'b000, 0, 4'h0, 0, 0, 0);
  endtask

  initial begin
    do_reset();
    // zero flag drives bz taken, then flush drops
    cyc(1, 3'b100, 0, 4'h0, 0, 0, 0);
    cyc(0, 3'b000, 1, 4'h2, 32'h10, 32'h100, 0);
    check("bz_taken", taken, 1);
    check("bz_pc", next_pc, 32'h100);
    idle();
    check("bz_flush_off", flush, 0);
    // same-cycle flag write does not steer the branch
    cyc(1, 3'b000, 0, 4'h0, 0, 0, 0);
    cyc(1, 3'b100, 1, 4'h2, 32'h20, 32'h300, 0);
    check("bz_same_cyc", taken, 0);
    check("bz_same_pc", next_pc, 32'h100);
    cyc(0, 3'b000, 1, 4'h2, 32'h24, 32'h304, 0);
    check("bz_later", taken, 1);
    idle();
    // bl, ignored shadow branch, then ret
    do_reset();
    cyc(0, 3'b000, 1, 4'h4, 32'h40, 32'h200, 0);
    check("bl_pc", next_pc, 32'h200);
    cyc(0, 3'b000, 1, 4'h1, 0, 32'h999, 0);
    check("shadow_ign", taken, 0);
    cyc(0, 3'b000, 1, 4'h8, 0, 0, 32'h777);
    check("ret_pc", next_pc, 32'h44);
    idle();
    // overflow then drain to underflow
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cyc(0, 3'b000, 1, 4'h4, 32'(i * 16), 32'h500, 0);
      idle();
    end
    check("ovf_set", ras_overflow, 1);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 3'b000, 1, 4'h8, 0, 0, 32'hABC0);
      check("ret_seq", next_pc, i < 4 ? 32'(32'h44 - i * 16) : 32'hABC0);
      check("ret_unf", ras_underflow, i == 4);
      idle();
    end
    // reserved encoding has no effect
    cyc(0, 3'b000, 1, 4'hA, 32'h60, 32'h600, 32'h601);
    check("rsv_taken", taken, 0);
    // reset in shadow, then bnz with cleared flags
    cyc(1, 3'b100, 1, 4'h1, 0, 32'h800, 0);
    do_reset();
    cyc(0, 3'b000, 1, 4'h3, 0, 32'h900, 0);
    check("bnz_post_rst", taken, 1);
    check("bnz_pc", next_pc, 32'h900);
    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [3:0] bt;
      bt = 4'($urandom_range(0, 10));
      if (bt > 8) bt = 4'($urandom_range(9, 15));
      cyc(1'($urandom_range(0, 2) == 0), 3'($urandom), 1'($urandom_range(0, 3) != 0), bt,
          $urandom, $urandom, $urandom);
      if ($urandom_range(0, 99) == 0) do_reset();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/branch_unit.md
BRANCH_UNIT -- requirements
Module: branch_unit

Interface
REQ-001 Parameter ADDR_W, default 32, width of PC, target and link addresses.
REQ-002 Parameter RAS_DEPTH, default 4, return-address-stack entries; any value >= 2 is legal.
REQ-003 Parameter PC_STEP, default 4, increment added to pc_in to form the link address.
REQ-004 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port rst_n  input  1  reset; asynchronous and active-low.
REQ-006 Port flag_we  input  1  load alu_zero, alu_carry and alu_sign into the flag register.
REQ-007 Port alu_zero, alu_carry, alu_sign  input  1 each  ALU status bits.
REQ-008 Port br_valid  input  1  a branch-class instruction is presented this cycle.
REQ-009 Port br_type  input  4  branch encoding, defined below.
REQ-010 Port pc_in  input  ADDR_W  PC of the presented instruction.
REQ-011 Port imm_target  input  ADDR_W  precomputed PC-relative or absolute target.
REQ-012 Port reg_target  input  ADDR_W  register-sourced target.
REQ-013 Port taken  output  1  registered; the branch resolved taken.
REQ-014 Port next_pc  output  ADDR_W  registered redirect address; valid when taken=1.
REQ-015 Port flush  output  1  registered one-cycle pulse; squash the fetched instruction.
REQ-016 Port ras_overflow  output  1  sticky; a push hit a full stack.
REQ-017 Port ras_underflow  output  1  one-cycle pulse; a ret hit an empty stack.

Function
REQ-018 Decode: 0000 br (reg_target, always); 0001 b (imm, always); 0010 bz (imm, Z=1); 0011 bnz (imm, Z=0); 0100 bl (imm, always, push); 0101 bcy (imm, C=1); 0110 bltz (imm, S=1); 0111 bncy (imm, C=0); 1000 ret (pop, always); 1001-1111 are reserved and resolve not taken with no side effects.
REQ-019 Conditions use the flag register value held before the current edge; a flag_we in the same cycle as br_valid does not affect that branch.
REQ-020 The flag register loads all three bits on flag_we, independent of br_valid.
REQ-021 Latency is 1 cycle: taken, next_pc and flush reflect the br_valid cycle on the following edge.
REQ-022 On a resolved taken branch: taken=1, flush=1 for exactly one cycle.
REQ-023 On a not-taken, reserved or idle cycle: taken=0, flush=0, and next_pc holds its previous value.
REQ-024 FSM states: NORMAL and SHADOW. A taken resolution moves the FSM to SHADOW for exactly one cycle, then it returns to NORMAL.
REQ-025 In SHADOW, br_valid is ignored: no resolution, no RAS change, taken=0 on the next cycle. flag_we still applies.
REQ-026 bl pushes pc_in+PC_STEP, computed modulo 2^ADDR_W, onto the RAS.
REQ-027 ret pops the top of the RAS; next_pc takes the popped value.
REQ-028 RAS is circular. A push when full overwrites the oldest entry, leaves the count at RAS_DEPTH, and sets ras_overflow, which stays set until reset.
REQ-029 A ret on an empty RAS redirects to reg_target, leaves the count at 0, and pulses ras_underflow on the output cycle.
REQ-030 Count stays within 0..RAS_DEPTH at all times. Pointer wrap is modulo RAS_DEPTH, including when RAS_DEPTH is not a power of two.

Reset
REQ-031 Asserting rst_n=0 at any time, including mid-resolution or in SHADOW, immediately clears taken, flush, ras_underflow and ras_overflow to 0, next_pc to 0, flags to 0, RAS count to 0, and the FSM to NORMAL.
REQ-032 RAS entry contents are don't-care after reset; the bench never observes an entry before it has been pushed.
REQ-033 The first edge after rst_n deasserts behaves as NORMAL with flags=000.

Verification
REQ-034 flag_we with Z=1; next cycle bz, imm_target=0x100 -> next cycle taken=1, next_pc=0x100, flush=1; following cycle flush=0.
REQ-035 Same cycle: flag_we Z=1 and bz, with prior Z=0 -> taken=0, next_pc unchanged.
REQ-036 bl at pc_in=0x40, imm_target=0x200; SHADOW cycle with br_valid ignored; later ret -> next_pc=0x44, taken=1.
REQ-037 RAS_DEPTH=4: five bl at PCs 0x0,0x10,0x20,0x30,0x40 -> ras_overflow=1; five ret -> next_pc 0x44,0x34,0x24,0x14; fifth ret -> ras_underflow pulse and next_pc=reg_target.
REQ-038 br_type=1010 with br_valid -> taken=0, flush=0, RAS count unchanged.
REQ-039 rst_n pulsed low during SHADOW after a taken b -> all outputs 0 immediately; next bnz with Z=0 is resolved taken.
